// File: rtl/bus_arbiter_4_rr.sv
// rtl/bus_arbiter_4_rr.sv - 4-way round-robin arbiter with turnaround cycle for a tri-state bus mux
// Optional forced release after HOLD_MAX grant cycles is enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter_4_rr #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] grant,
    output logic [1:0] select,
    output logic       enable,
    output logic       busy,
    output logic       abort,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] select_q, select_d;
    logic       enable_q, enable_d;
    logic       abort_q, abort_d;
    logic       timeout_q, timeout_d;
    logic [2:0] win;
`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_q, hold_d;
`endif

    // Returns {found, index}; the scan starts just after the last winner.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = p + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        select_d  = select_q;
        enable_d  = enable_q;
        abort_d   = 1'b0;
        timeout_d = 1'b0;
        win       = pick(req, ptr_q);
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
`endif
        case (state_q)
            IDLE, TURN: begin
                if (win[2]) begin
                    state_d  = GRANT;
                    grant_d  = 4'b0001 << win[1:0];
                    select_d = win[1:0];
                    enable_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_d   = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (done[select_q] || !req[select_q]) begin
                    state_d  = TURN;
                    grant_d  = 4'b0000;
                    enable_d = 1'b0;
                    ptr_d    = select_q;
                    abort_d  = !done[select_q];
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q == CNT_W'(HOLD_MAX - 1)) begin
                    state_d   = TURN;
                    grant_d   = 4'b0000;
                    enable_d  = 1'b0;
                    ptr_d     = select_q;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd3;
            grant_q   <= 4'b0000;
            select_q  <= 2'd0;
            enable_q  <= 1'b0;
            abort_q   <= 1'b0;
            timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            select_q  <= select_d;
            enable_q  <= enable_d;
            abort_q   <= abort_d;
            timeout_q <= timeout_d;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= hold_d;
`endif
        end
    end

    assign grant   = grant_q;
    assign select  = select_q;
    assign enable  = enable_q;
    assign busy    = (state_q != IDLE);
    assign abort   = abort_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_4_rr.sv
// tb/tb_bus_arbiter_4_rr.sv - self-checking bench for bus_arbiter_4_rr
module tb_bus_arbiter_4_rr;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = 4'b0000;
    logic [3:0] done  = 4'b0000;
    logic [3:0] grant;
    logic [1:0] select;
    logic       enable, busy, abort, timeout;

    int errors = 0;
    int checks = 0;

    bus_arbiter_4_rr #(.HOLD_MAX(16), .CNT_W(5)) dut (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .done   (done),
        .grant  (grant),
        .select (select),
        .enable (enable),
        .busy   (busy),
        .abort  (abort),
        .timeout(timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       en;
        logic       busy;
        logic       abort;
        logic       tmo;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [3:0] g, input logic [1:0] s,
                           input logic e, input logic b, input logic a, input logic t);
        chk({name, ".grant"},   grant,          g);
        chk({name, ".select"},  {2'b00, select}, {2'b00, s});
        chk({name, ".enable"},  {3'b000, enable},  {3'b000, e});
        chk({name, ".busy"},    {3'b000, busy},    {3'b000, b});
        chk({name, ".abort"},   {3'b000, abort},   {3'b000, a});
        chk({name, ".timeout"}, {3'b000, timeout}, {3'b000, t});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        req   = 4'b0000;
        done  = 4'b0000;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        // Directed vectors: inputs applied, one edge, then outputs compared.
        vecs[0]  = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{4'b0100, 4'b0010, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{4'b0101, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{4'b0101, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        #2;
        chk_all("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            req  = vecs[i].req;
            done = vecs[i].done;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel,
                    vecs[i].en, vecs[i].busy, vecs[i].abort, vecs[i].tmo);
        end

        // All four requesting: rotation 0,1,2,3,0 with one idle bus cycle between owners.
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            for (int c = 1; c <= 3; c++) begin
                chk_all($sformatf("rr_k%0d_c%0d", k, c), 4'b0001 << (k % 4), 2'(k % 4),
                        1'b1, 1'b1, 1'b0, 1'b0);
                if (c < 3) step();
            end
            done = 4'b0001 << (k % 4);
            step();
            done = 4'b0000;
            chk_all($sformatf("rr_turn%0d", k), 4'b0000, 2'(k % 4), 1'b0, 1'b1, 1'b0, 1'b0);
        end

        // Long hold by requester 3.
        do_reset();
        req = 4'b1000;
        step();
        chk_all("hold_grant", 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int c = 2; c <= 16; c++) begin
            step();
            chk_all($sformatf("hold_c%0d", c), 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        step();
        chk_all("timeout_turn", 4'b0000, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        chk_all("timeout_regrant", 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
`else
        for (int c = 2; c <= 120; c++) begin
            step();
            if (c % 20 == 0)
                chk_all($sformatf("hold_c%0d", c), 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        end
`endif

        // Asynchronous reset in the middle of a grant; pointer returns to 3.
        do_reset();
        req = 4'b0100;
        step();
        chk_all("pre_reset_grant", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        req   = 4'b1010;
        reset = 1'b1;
        #1;
        chk_all("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("held_reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        chk_all("post_reset_grant", 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
